// File: rtl/unpack_blk_to_stream_sdiv_65s_34ns_seq_if.sv
// unpack_blk_to_stream_sdiv_65s_34ns_seq_if: operand/result handshake bundle for the signed divider
interface unpack_blk_to_stream_sdiv_65s_34ns_seq_if #(
  parameter int din0_WIDTH = 65,
  parameter int din1_WIDTH = 34
);
  logic in_valid;
  logic in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic out_valid;
  logic out_ready;
  logic [din0_WIDTH-1:0] dout_quot;
  logic [din1_WIDTH:0] dout_rem;
  logic div_by_zero;
  modport master (
    output in_valid, din0, din1, out_ready,
    input in_ready, out_valid, dout_quot, dout_rem, div_by_zero
  );
  modport slave (
    input in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout_quot, dout_rem, div_by_zero
  );
endinterface

// File: rtl/unpack_blk_to_stream_sdiv_65s_34ns_seq.sv
// unpack_blk_to_stream_sdiv_65s_34ns_seq: restoring signed/unsigned divider, one quotient bit per enabled cycle
module unpack_blk_to_stream_sdiv_65s_34ns_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 65,
  parameter int din1_WIDTH = 34
) (
  input logic clk,
  input logic reset,
  input logic ce,
  unpack_blk_to_stream_sdiv_65s_34ns_seq_if.slave bus
);
  localparam int CW = $clog2(din0_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic sign;
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] dsr;
  logic [din1_WIDTH:0] rem, sh, diff;
  logic [CW-1:0] count;
  logic unused_id;
  assign unused_id = ID[0];
  assign sh = {rem[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
  assign diff = sh - {1'b0, dsr};
  // dvd starts as |dividend| and is gradually replaced by the quotient from the LSB end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.dout_quot <= '0;
      bus.dout_rem <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= bus.din0[din0_WIDTH-1];
          dvd <= bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
          dsr <= bus.din1;
          rem <= '0;
          count <= CW'(din0_WIDTH);
          bus.in_ready <= 1'b0;
          bus.div_by_zero <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          rem <= diff[din1_WIDTH] ? sh : diff;
          dvd <= {dvd[din0_WIDTH-2:0], ~diff[din1_WIDTH]};
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          bus.dout_quot <= ~|dsr ? '1 : sign ? -dvd : dvd;
          bus.dout_rem <= ~|dsr ? '0 : sign ? -rem : rem;
          bus.div_by_zero <= ~|dsr;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unpack_blk_to_stream_sdiv_65s_34ns_seq.sv
// tb_unpack_blk_to_stream_sdiv_65s_34ns_seq: directed vector table plus flow-control and reset sequences
module tb_unpack_blk_to_stream_sdiv_65s_34ns_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  int total = 0;
  int passed = 0;
  int lat;
  unpack_blk_to_stream_sdiv_65s_34ns_seq_if bus ();
  unpack_blk_to_stream_sdiv_65s_34ns_seq dut (.clk(clk), .reset(reset), .ce(ce), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic signed [64:0] a;
    logic [33:0] b;
    logic signed [64:0] q;
    logic signed [34:0] r;
    logic z;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic start(input logic signed [64:0] a, input logic [33:0] b, input int gap, output int l);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din0 = a;
    bus.din1 = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 200) begin
      ce = (gap >= 0 && l >= gap && l < gap + 5) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      l++;
    end
    ce = 1'b1;
  endtask
  task automatic release_op(input string n);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk(n, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask
  initial begin
    vecs[0] = '{65'sd100, 34'd7, 65'sd14, 35'sd2, 1'b0};
    vecs[1] = '{-65'sd100, 34'd7, -65'sd14, -35'sd2, 1'b0};
    vecs[2] = '{-65'sd21, 34'd7, -65'sd3, 35'sd0, 1'b0};
    vecs[3] = '{65'h1_0000_0000_0000_0000, 34'd1, 65'h1_0000_0000_0000_0000, 35'sd0, 1'b0};
    vecs[4] = '{65'h0_FFFF_FFFF_FFFF_FFFF, 34'h3_FFFF_FFFF, 65'sd1073741824, 35'sd1073741823, 1'b0};
    vecs[5] = '{65'sd12345, 34'd0, 65'h1_FFFF_FFFF_FFFF_FFFF, 35'sd0, 1'b1};
    vecs[6] = '{65'sd9, 34'd3, 65'sd3, 35'sd0, 1'b0};
    bus.in_valid = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_hs", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("reset_data", {bus.dout_quot, bus.dout_rem, bus.div_by_zero}, '0);
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].a, vecs[i].b, -1, lat);
      chk($sformatf("quot[%0d]", i), bus.dout_quot, $unsigned(vecs[i].q));
      chk($sformatf("rem[%0d]", i), bus.dout_rem, $unsigned(vecs[i].r));
      chk($sformatf("dbz[%0d]", i), bus.div_by_zero, vecs[i].z);
      chk($sformatf("lat[%0d]", i), lat, 66);
      release_op($sformatf("release[%0d]", i));
    end
    // results must hold while the consumer stalls
    start(65'sd100, 34'd7, -1, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold[%0d]", i), {bus.out_valid, bus.in_ready, bus.dout_quot, bus.dout_rem},
          {1'b1, 1'b0, 65'd14, 35'd2});
    end
    release_op("release_hold");
    start(-65'sd100, 34'd7, 20, lat);
    chk("ce_lat", lat, 71);
    chk("ce_quot", bus.dout_quot, $unsigned(-65'sd14));
    chk("ce_rem", bus.dout_rem, $unsigned(-35'sd2));
    release_op("release_ce");
    // abandon an operation mid-iteration
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din0 = 65'd1000;
    bus.din1 = 34'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hs", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("midreset_data", {bus.dout_quot, bus.dout_rem, bus.div_by_zero}, '0);
    repeat (70) @(negedge clk);
    chk("midreset_noresult", bus.out_valid, 1'b0);
    start(65'sd50, 34'd5, -1, lat);
    chk("post_quot", bus.dout_quot, 65'd10);
    chk("post_rem", bus.dout_rem, 35'd0);
    chk("post_lat", lat, 66);
    release_op("release_post");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
